// File: rtl/spi_resp_pkg.sv
// Shared types and constants for the SPI responder.
package spi_resp_pkg;

   // Responder frame states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      REARM = 2'd3
   } state_t;

   // Flip-flop depth of each input synchronizer
   localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer followed by an edge register; produces the
// synchronized level plus single-cycle rise/fall strobes.
module sync_edge
   import spi_resp_pkg::*;
#(
   parameter logic IDLE_LEVEL = 1'b0
)
(
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_reg;
   logic                   edge_reg;

   // Synchronizer chain and one-cycle-delayed copy for edge detection
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_reg <= {SYNC_STAGES{IDLE_LEVEL}};
         edge_reg <= IDLE_LEVEL;
      end else begin
         sync_reg <= {sync_reg[SYNC_STAGES-2:0], din};
         edge_reg <= sync_reg[SYNC_STAGES-1];
      end
   end

   assign level = sync_reg[SYNC_STAGES-1];
   assign rise  = level & ~edge_reg;
   assign fall  = ~level & edge_reg;

endmodule

// File: rtl/spi_slave_responder.sv
// Mode-0 SPI responder: oversampled SCLK/MOSI/SS, parallel receive word,
// valid/ready holding register for the word returned on MISO.
module spi_slave_responder
   import spi_resp_pkg::*;
#(
   parameter int                    DATA_WIDTH = 8,
   parameter logic [DATA_WIDTH-1:0] DEFAULT_TX = '1
)
(
   input  logic                  SYSCLK,
   input  logic                  SYSRESET,
   input  logic                  SPISCLKO,
   input  logic                  SPISDO,
   input  logic                  SPISS,
   output logic                  SPISDI,
   output logic                  miso_oe,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   output logic                  tx_underrun,
   output logic                  frame_err,
   output logic                  busy
);

   localparam int                CNT_W   = $clog2(DATA_WIDTH);
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DATA_WIDTH - 1);

   logic sclk_level_unused, sclk_rise, sclk_fall;
   logic mosi_level, mosi_rise_unused, mosi_fall_unused;
   logic ss_level, ss_rise, ss_fall;

   sync_edge #(.IDLE_LEVEL(1'b0)) u_sync_sclk (
      .clk(SYSCLK), .rst(SYSRESET), .din(SPISCLKO),
      .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall));

   sync_edge #(.IDLE_LEVEL(1'b0)) u_sync_mosi (
      .clk(SYSCLK), .rst(SYSRESET), .din(SPISDO),
      .level(mosi_level), .rise(mosi_rise_unused), .fall(mosi_fall_unused));

   sync_edge #(.IDLE_LEVEL(1'b1)) u_sync_ss (
      .clk(SYSCLK), .rst(SYSRESET), .din(SPISS),
      .level(ss_level), .rise(ss_rise), .fall(ss_fall));

   state_t                  state_reg, state_next;
   logic                    armed_reg;
   logic [SYNC_STAGES-1:0]  settle_reg;
   logic [CNT_W-1:0]        bit_cnt_reg;
   logic [DATA_WIDTH-2:0]   rx_shift_reg;
   logic [DATA_WIDTH-1:0]   rx_data_reg;
   logic [DATA_WIDTH-1:0]   tx_shift_reg;
   logic [DATA_WIDTH-1:0]   hold_data_reg;
   logic                    hold_full_reg;
   logic                    rx_valid_reg, underrun_reg, frame_err_reg;
   logic                    spisdi_reg, miso_oe_reg;

   logic                    load_en, sample_en, shift_en, word_done, abort_err, cnt_clear;
   logic [DATA_WIDTH-1:0]   rx_word, load_word;

   assign rx_word   = {rx_shift_reg, mosi_level};
   assign load_word = hold_full_reg ? hold_data_reg : DEFAULT_TX;

   // State register
   always_ff @(posedge SYSCLK or posedge SYSRESET) begin
      if (SYSRESET) state_reg <= IDLE;
      else          state_reg <= state_next;
   end

   // Next-state and datapath control; SS deassertion overrides SCLK edges,
   // except that a word completing in the same cycle is still delivered.
   always_comb begin
      state_next = state_reg;
      load_en    = 1'b0;
      sample_en  = 1'b0;
      shift_en   = 1'b0;
      word_done  = 1'b0;
      abort_err  = 1'b0;
      cnt_clear  = 1'b0;
      case (state_reg)
         IDLE:  if (ss_fall && armed_reg) state_next = LOAD;
         LOAD:  begin
                   load_en    = 1'b1;
                   state_next = SHIFT;
                end
         SHIFT: begin
                   if (sclk_rise) begin
                      sample_en = 1'b1;
                      if (bit_cnt_reg == CNT_MAX) begin
                         word_done  = 1'b1;
                         state_next = REARM;
                      end
                   end else if (sclk_fall) begin
                      shift_en = 1'b1;
                   end
                end
         REARM: if (sclk_fall) begin
                   load_en    = 1'b1;
                   state_next = SHIFT;
                end
         default: state_next = IDLE;
      endcase
      if (ss_rise) begin
         load_en    = 1'b0;
         shift_en   = 1'b0;
         cnt_clear  = 1'b1;
         state_next = IDLE;
         if (!word_done) begin
            sample_en = 1'b0;
            abort_err = (bit_cnt_reg != '0);
         end
      end
   end

   // Datapath: arming, receive shifter, transmit shifter, holding register, pins
   always_ff @(posedge SYSCLK or posedge SYSRESET) begin
      if (SYSRESET) begin
         armed_reg     <= 1'b0;
         settle_reg    <= '0;
         bit_cnt_reg   <= '0;
         rx_shift_reg  <= '0;
         rx_data_reg   <= '0;
         tx_shift_reg  <= '0;
         hold_data_reg <= '0;
         hold_full_reg <= 1'b0;
         rx_valid_reg  <= 1'b0;
         underrun_reg  <= 1'b0;
         frame_err_reg <= 1'b0;
         spisdi_reg    <= 1'b1;
         miso_oe_reg   <= 1'b0;
      end else begin
         // The synchronizer reset values are not samples of the pin, so
         // arming waits until the chain has been refilled from SS itself;
         // a frame already in progress at reset is then ignored until SS rises.
         settle_reg <= {settle_reg[SYNC_STAGES-2:0], 1'b1};
         if (settle_reg[SYNC_STAGES-1] && ss_level) armed_reg <= 1'b1;

         rx_valid_reg  <= 1'b0;
         frame_err_reg <= abort_err;
         if (sample_en) begin
            rx_shift_reg <= rx_word[DATA_WIDTH-2:0];
            if (word_done) begin
               rx_data_reg  <= rx_word;
               rx_valid_reg <= 1'b1;
            end
         end
         if (word_done || cnt_clear) bit_cnt_reg <= '0;
         else if (sample_en)         bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);

         underrun_reg <= load_en & ~hold_full_reg;
         if (load_en)       tx_shift_reg <= load_word;
         else if (shift_en) tx_shift_reg <= {tx_shift_reg[DATA_WIDTH-2:0], 1'b0};

         // A load empties a full register; an empty register accepts tx_data
         // even in a load cycle (that load still takes DEFAULT_TX).
         if (load_en && hold_full_reg) begin
            hold_full_reg <= 1'b0;
         end else if (tx_valid && !hold_full_reg) begin
            hold_full_reg <= 1'b1;
            hold_data_reg <= tx_data;
         end

         miso_oe_reg <= (state_reg != IDLE);
         if (state_reg == IDLE)      spisdi_reg <= 1'b1;
         else if (state_reg == LOAD) spisdi_reg <= load_word[DATA_WIDTH-1];
         else                        spisdi_reg <= tx_shift_reg[DATA_WIDTH-1];
      end
   end

   assign SPISDI      = spisdi_reg;
   assign miso_oe     = miso_oe_reg;
   assign rx_data     = rx_data_reg;
   assign rx_valid    = rx_valid_reg;
   assign tx_ready    = ~hold_full_reg;
   assign tx_underrun = underrun_reg;
   assign frame_err   = frame_err_reg;
   assign busy        = (state_reg != IDLE);

endmodule
